intensity_ramp_pwm: RTL and testbench
=====================================

Name: intensity_ramp_pwm

Overview:
Consumes the 4-bit proximity intensity (0 = far/none, 8 = closest) from the ultrasonic distance stage. Samples it once per sensor measurement period and rejects glitches by requiring several identical consecutive samples. Slews an output level toward the accepted value one step at a time and drives a PWM pin (LED or haptic driver) whose duty is proportional to that level. Runs in the 40 MHz clk domain and sits directly downstream of the distance block.

Parameters:
SAMPLE_DIV, 2400000, clk cycles per input sample tick (60 ms at 40 MHz, matches sensor cycle)
STABLE_COUNT, 3, consecutive identical samples required to accept a new target (>=1)
RAMP_DIV, 400000, clk cycles per ramp step tick (10 ms at 40 MHz)
PWM_BITS, 8, PWM counter width; period = 2^PWM_BITS clk cycles
MAX_LEVEL, 8, highest legal intensity; must evenly divide 2^PWM_BITS

Ports:
clk  input  1  40 MHz system clock
reset  input  1  asynchronous, active-high reset
intensity_in  input  4  intensity from distance stage, quasi-static
enable  input  1  1 = PWM may drive; 0 = pwm_out forced low
pwm_out  output  1  registered PWM output
level  output  4  current ramped level, 0..MAX_LEVEL
target  output  4  last accepted (debounced) intensity
at_target  output  1  1 when level == target

Behaviour:
- Reset: reset resets asynchronously, active-high; clock is clk. While reset is high, all registers go to 0: sample/ramp/PWM counters, candidate, stable count, target, level, pwm_out. at_target therefore reads 1. Reset mid-operation abandons any ramp or filter progress. No tick fires in the first clk after release.
- Sample tick: counter counts 0..SAMPLE_DIV-1 and wraps. The tick is a 1-clk pulse when count == SAMPLE_DIV-1.
- Input sanitising: intensity_in > MAX_LEVEL is treated as 0 (invalid reading = no presence).
- Filter, on sample tick, using sanitised value s:
  - If s == candidate, stable count saturates-increments at STABLE_COUNT.
  - Otherwise candidate <= s and stable count <= 1.
  - target <= candidate when the updated stable count equals STABLE_COUNT. This also covers STABLE_COUNT = 1, where target follows every sample.
  - A changed input updates target on the STABLE_COUNT-th consecutive tick seeing it.
  - Alternating values never update target.
- Ramp tick: independent counter 0..RAMP_DIV-1. 1-clk pulse at RAMP_DIV-1.
  - level < target: level + 1.
  - level > target: level - 1.
  - Equal: hold.
  - Exactly one step per ramp tick. Never overshoots.
- Simultaneous sample and ramp tick in the same clk: ramp compares against the pre-update target. The new target is used from the next ramp tick.
- at_target: combinational (level == target).
- PWM:
  - pwm counter of PWM_BITS width, free-running, wraps 2^PWM_BITS-1 -> 0.
  - duty = level * (2^PWM_BITS / MAX_LEVEL), held at PWM_BITS+1 bits.
  - pwm_out <= enable && (pwm_cnt < duty), registered with 1-clk latency.
  - level 0 gives a constant 0. level MAX_LEVEL gives a constant 1 (duty 2^PWM_BITS exceeds every count).
  - Level changes take effect on the next compare. No period-boundary synchronisation is required.
- enable low: pwm_out is 0 on the following clk. Filter, ramp and counters keep running.
- All arithmetic is unsigned, and counters wrap only at the stated terminal values.

Test Plan:
Bench parameters: SAMPLE_DIV=10, RAMP_DIV=4, STABLE_COUNT=3, PWM_BITS=4, MAX_LEVEL=8 (duty = level*2, period 16).
- Reset check: assert reset mid-run with level=5 -> level, target, pwm_out = 0 immediately (asynchronous), at_target=1, pwm_out low for 16 clk after release.
- Debounce: hold intensity_in=6 from reset -> target=6 exactly on the 3rd sample tick (clk 30 after release), not before.
- Glitch rejection: target=6 steady; present 2 for one sample then 6 again -> target stays 6. Alternate 2/6 each sample for 10 samples -> target stays 6.
- Ramp: target jumps 0->6 -> level steps 1,2,...,6 on successive ramp ticks (one per 4 clk) and at_target=1 after the 6th. Target 6->1 -> level decrements by 1 per tick to 1.
- PWM duty: level=3, enable=1 -> pwm_out high 6 of every 16 clk. Level=8 -> constantly 1. Level=0 -> constantly 0. Drop enable -> 0 on the next clk.
- Invalid input: intensity_in=12 for 3 samples -> target=0. Simultaneous ramp/sample tick on the accepting clk -> level unchanged that clk, starts moving on the next ramp tick.

Source files
------------

// File: rtl/intensity_ramp_pwm.sv
// intensity_ramp_pwm: debounces the proximity intensity from the distance stage,
// slews an output level toward the accepted value one step per ramp tick and
// drives a PWM pin whose duty is proportional to that level.
module intensity_ramp_pwm #(
  parameter int SAMPLE_DIV   = 2400000,
  parameter int STABLE_COUNT = 3,
  parameter int RAMP_DIV     = 400000,
  parameter int PWM_BITS     = 8,
  parameter int MAX_LEVEL    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] intensity_in,
  input  logic       enable,
  output logic       pwm_out,
  output logic [3:0] level,
  output logic [3:0] target,
  output logic       at_target
);

  localparam int SAMPLE_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int RAMP_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int STABLE_W  = $clog2(STABLE_COUNT + 1);
  localparam int DUTY_W    = PWM_BITS + 1;
  localparam int DUTY_STEP = (2 ** PWM_BITS) / MAX_LEVEL;

  localparam logic [SAMPLE_W-1:0] SAMPLE_LAST = SAMPLE_W'(SAMPLE_DIV - 1);
  localparam logic [RAMP_W-1:0]   RAMP_LAST   = RAMP_W'(RAMP_DIV - 1);
  localparam logic [STABLE_W-1:0] STABLE_FULL = STABLE_W'(STABLE_COUNT);
  localparam logic [STABLE_W-1:0] STABLE_ONE  = STABLE_W'(1);
  localparam logic [3:0]          MAX_LVL     = 4'(MAX_LEVEL);
  localparam logic [DUTY_W-1:0]   DUTY_INC    = DUTY_W'(DUTY_STEP);

  logic [SAMPLE_W-1:0] sample_cnt;
  logic                sample_tick;
  logic [RAMP_W-1:0]   ramp_cnt;
  logic                ramp_tick;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [3:0]          sanitized;
  logic [3:0]          candidate;
  logic [STABLE_W-1:0] stable_cnt;
  logic [STABLE_W-1:0] stable_next;
  logic [DUTY_W-1:0]   duty;

  assign sample_tick = (sample_cnt == SAMPLE_LAST);
  assign ramp_tick   = (ramp_cnt == RAMP_LAST);
  assign at_target   = (level == target);

  // Duty is one bit wider than the counter so full level stays high all period.
  assign duty = DUTY_W'(level) * DUTY_INC;

  // Sample-period divider; counters start at 0 so no tick fires right after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_cnt <= '0;
    end else if (sample_tick) begin
      sample_cnt <= '0;
    end else begin
      sample_cnt <= sample_cnt + 1'b1;
    end
  end

  // Ramp-step divider, independent of the sample divider.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ramp_cnt <= '0;
    end else if (ramp_tick) begin
      ramp_cnt <= '0;
    end else begin
      ramp_cnt <= ramp_cnt + 1'b1;
    end
  end

  // Out-of-range readings mean "no presence"; run length of identical samples saturates.
  always_comb begin
    sanitized = (intensity_in > MAX_LVL) ? 4'd0 : intensity_in;
    if (sanitized == candidate) begin
      stable_next = (stable_cnt == STABLE_FULL) ? stable_cnt : stable_cnt + 1'b1;
    end else begin
      stable_next = STABLE_ONE;
    end
  end

  // Glitch filter: accept a value once it has been seen on enough consecutive ticks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      candidate  <= '0;
      stable_cnt <= '0;
      target     <= '0;
    end else if (sample_tick) begin
      candidate  <= sanitized;
      stable_cnt <= stable_next;
      if (stable_next == STABLE_FULL) begin
        target <= sanitized;
      end
    end
  end

  // Slew level one step per ramp tick toward the target held before this edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level <= '0;
    end else if (ramp_tick) begin
      if (level < target) begin
        level <= level + 1'b1;
      end else if (level > target) begin
        level <= level - 1'b1;
      end
    end
  end

  // Free-running PWM counter with registered compare; enable gates the pin only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt <= '0;
      pwm_out <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      pwm_out <= enable && ({1'b0, pwm_cnt} < duty);
    end
  end

endmodule

// File: tb/tb_intensity_ramp_pwm.sv
// Bench for intensity_ramp_pwm: directed scenarios plus randomized traffic,
// all checked against an edge-indexed behavioural model of the block.
module tb_intensity_ramp_pwm;

  localparam int SAMPLE_DIV   = 10;
  localparam int RAMP_DIV     = 4;
  localparam int STABLE_COUNT = 3;
  localparam int PWM_BITS     = 4;
  localparam int MAX_LEVEL    = 8;
  localparam int PERIOD       = 1 << PWM_BITS;
  localparam int DUTY_STEP    = PERIOD / MAX_LEVEL;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [3:0] intensity_in;
  logic       pwm_out;
  logic [3:0] level;
  logic [3:0] target;
  logic       at_target;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: m_n is the number of clk edges since reset release.
  int         m_n;
  logic [3:0] m_hist[$];
  logic [3:0] m_target;
  logic [3:0] m_level;
  logic       m_pwm;
  logic [3:0] m_s;
  bit         m_all;

  intensity_ramp_pwm #(
    .SAMPLE_DIV  (SAMPLE_DIV),
    .STABLE_COUNT(STABLE_COUNT),
    .RAMP_DIV    (RAMP_DIV),
    .PWM_BITS    (PWM_BITS),
    .MAX_LEVEL   (MAX_LEVEL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .intensity_in(intensity_in),
    .enable      (enable),
    .pwm_out     (pwm_out),
    .level       (level),
    .target      (target),
    .at_target   (at_target)
  );

  initial clk = 1'b0;
  // 10-unit clock period.
  always #5 clk = ~clk;

  // Model: edge n samples on multiples of SAMPLE_DIV, ramps on multiples of RAMP_DIV;
  // target = value of the last STABLE_COUNT samples when they all agree.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_n      = 0;
      m_hist.delete();
      m_target = 4'd0;
      m_level  = 4'd0;
      m_pwm    = 1'b0;
    end else begin
      m_n   = m_n + 1;
      m_pwm = enable && (((m_n - 1) % PERIOD) < int'(m_level) * DUTY_STEP);
      if (m_n % RAMP_DIV == 0) begin
        if (m_level < m_target) m_level = m_level + 4'd1;
        else if (m_level > m_target) m_level = m_level - 4'd1;
      end
      if (m_n % SAMPLE_DIV == 0) begin
        m_s = (int'(intensity_in) > MAX_LEVEL) ? 4'd0 : intensity_in;
        m_hist.push_back(m_s);
        if (m_hist.size() > STABLE_COUNT) void'(m_hist.pop_front());
        if (m_hist.size() == STABLE_COUNT) begin
          m_all = 1'b1;
          foreach (m_hist[i]) if (m_hist[i] !== m_s) m_all = 1'b0;
          if (m_all) m_target = m_s;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset(input logic [3:0] v);
    @(negedge clk);
    reset        = 1'b1;
    intensity_in = v;
    enable       = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset(4'd5);
    repeat (60) step();
    n_checks++;
    if (level !== 4'd5) begin
      n_fail++; $display("FAIL reset_pre_level: got %0d expected %0d", level, 5);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (level !== 4'd0) begin
      n_fail++; $display("FAIL reset_async_level: got %0d expected 0", level);
    end
    n_checks++;
    if (target !== 4'd0) begin
      n_fail++; $display("FAIL reset_async_target: got %0d expected 0", target);
    end
    n_checks++;
    if (pwm_out !== 1'b0) begin
      n_fail++; $display("FAIL reset_async_pwm: got %b expected 0", pwm_out);
    end
    n_checks++;
    if (at_target !== 1'b1) begin
      n_fail++; $display("FAIL reset_at_target: got %b expected 1", at_target);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      n_checks++;
      if (pwm_out !== 1'b0) begin
        n_fail++; $display("FAIL reset_pwm_low: clk %0d got %b expected 0", i + 1, pwm_out);
      end
    end
  endtask

  task automatic test_debounce();
    apply_reset(4'd6);
    for (int n = 1; n <= 30; n++) begin
      logic [3:0] exp_t;
      step();
      exp_t = (n >= 30) ? 4'd6 : 4'd0;
      n_checks++;
      if (target !== exp_t) begin
        n_fail++; $display("FAIL debounce_target: clk %0d got %0d expected %0d", n, target, exp_t);
      end
    end
  endtask

  task automatic test_ramp_up();
    for (int n = 31; n <= 56; n++) begin
      int exp_l;
      step();
      exp_l = (n < 32) ? 0 : (((n - 28) / 4 > 6) ? 6 : (n - 28) / 4);
      n_checks++;
      if (level !== 4'(exp_l)) begin
        n_fail++; $display("FAIL ramp_up_level: clk %0d got %0d expected %0d", n, level, exp_l);
      end
      n_checks++;
      if (at_target !== (exp_l == 6)) begin
        n_fail++; $display("FAIL ramp_up_at_target: clk %0d got %b expected %b", n, at_target, exp_l == 6);
      end
    end
  endtask

  task automatic test_glitch();
    intensity_in = 4'd2;
    for (int i = 0; i < SAMPLE_DIV; i++) begin
      step();
      n_checks++;
      if (target !== 4'd6) begin
        n_fail++; $display("FAIL glitch_single: got %0d expected 6", target);
      end
      if (m_n % SAMPLE_DIV == 0) break;
    end
    intensity_in = 4'd6;
    for (int i = 0; i < 30; i++) begin
      step();
      n_checks++;
      if (target !== 4'd6) begin
        n_fail++; $display("FAIL glitch_recover: got %0d expected 6", target);
      end
    end
    for (int k = 0; k < 10; k++) begin
      intensity_in = (k % 2 == 1) ? 4'd6 : 4'd2;
      for (int i = 0; i < SAMPLE_DIV; i++) begin
        step();
        n_checks++;
        if (target !== 4'd6) begin
          n_fail++; $display("FAIL glitch_alternate: sample %0d got %0d expected 6", k, target);
        end
        if (m_n % SAMPLE_DIV == 0) break;
      end
    end
  endtask

  task automatic test_ramp_down();
    logic [3:0] prev;
    intensity_in = 4'd1;
    prev = level;
    for (int i = 0; i < 80; i++) begin
      step();
      n_checks++;
      if (level !== m_level) begin
        n_fail++; $display("FAIL ramp_down_level: got %0d expected %0d", level, m_level);
      end
      n_checks++;
      if (level > prev || (prev - level) > 4'd1) begin
        n_fail++; $display("FAIL ramp_down_step: got %0d after %0d expected a step of at most 1 down", level, prev);
      end
      prev = level;
    end
    n_checks++;
    if (level !== 4'd1) begin
      n_fail++; $display("FAIL ramp_down_final: got %0d expected 1", level);
    end
    n_checks++;
    if (at_target !== 1'b1) begin
      n_fail++; $display("FAIL ramp_down_at_target: got %b expected 1", at_target);
    end
  endtask

  task automatic test_pwm();
    int highs;
    intensity_in = 4'd3;
    repeat (80) step();
    n_checks++;
    if (level !== 4'd3) begin
      n_fail++; $display("FAIL pwm_level3_setup: got %0d expected 3", level);
    end
    highs = 0;
    for (int i = 0; i < PERIOD; i++) begin
      step();
      if (pwm_out === 1'b1) highs++;
      n_checks++;
      if (pwm_out !== m_pwm) begin
        n_fail++; $display("FAIL pwm_level3_bit: got %b expected %b", pwm_out, m_pwm);
      end
    end
    n_checks++;
    if (highs != 6) begin
      n_fail++; $display("FAIL pwm_level3_duty: got %0d high clks expected 6", highs);
    end
    intensity_in = 4'd8;
    repeat (80) step();
    n_checks++;
    if (level !== 4'd8) begin
      n_fail++; $display("FAIL pwm_level8_setup: got %0d expected 8", level);
    end
    for (int i = 0; i < PERIOD; i++) begin
      step();
      n_checks++;
      if (pwm_out !== 1'b1) begin
        n_fail++; $display("FAIL pwm_level8_high: got %b expected 1", pwm_out);
      end
    end
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (pwm_out !== 1'b0) begin
        n_fail++; $display("FAIL pwm_enable_low: clk %0d got %b expected 0", i + 1, pwm_out);
      end
    end
    enable = 1'b1;
    intensity_in = 4'd0;
    repeat (100) step();
    n_checks++;
    if (level !== 4'd0) begin
      n_fail++; $display("FAIL pwm_level0_setup: got %0d expected 0", level);
    end
    for (int i = 0; i < PERIOD; i++) begin
      step();
      n_checks++;
      if (pwm_out !== 1'b0) begin
        n_fail++; $display("FAIL pwm_level0_low: got %b expected 0", pwm_out);
      end
    end
  endtask

  task automatic test_invalid();
    intensity_in = 4'd5;
    repeat (80) step();
    n_checks++;
    if (target !== 4'd5 || level !== 4'd5) begin
      n_fail++; $display("FAIL invalid_setup: got target %0d level %0d expected 5 5", target, level);
    end
    // Align so the third invalid sample lands on a clk that is also a ramp tick.
    for (int i = 0; i < 2 * SAMPLE_DIV; i++) begin
      if (m_n % (2 * SAMPLE_DIV) == SAMPLE_DIV) break;
      step();
    end
    intensity_in = 4'd12;
    for (int i = 1; i <= 34; i++) begin
      logic [3:0] exp_t;
      logic [3:0] exp_l;
      step();
      exp_t = (i >= 30) ? 4'd0 : 4'd5;
      exp_l = (i >= 34) ? 4'd4 : 4'd5;
      n_checks++;
      if (target !== exp_t) begin
        n_fail++; $display("FAIL invalid_target: clk %0d got %0d expected %0d", i, target, exp_t);
      end
      n_checks++;
      if (level !== exp_l) begin
        n_fail++; $display("FAIL invalid_level: clk %0d got %0d expected %0d", i, level, exp_l);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 39) == 0) intensity_in = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) enable = ~enable;
      if (i == 400) begin
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
      step();
      n_checks++;
      if (level !== m_level) begin
        n_fail++; $display("FAIL random_level: iter %0d got %0d expected %0d", i, level, m_level);
      end
      n_checks++;
      if (target !== m_target) begin
        n_fail++; $display("FAIL random_target: iter %0d got %0d expected %0d", i, target, m_target);
      end
      n_checks++;
      if (pwm_out !== m_pwm) begin
        n_fail++; $display("FAIL random_pwm: iter %0d got %b expected %b", i, pwm_out, m_pwm);
      end
      n_checks++;
      if (at_target !== (m_level == m_target)) begin
        n_fail++; $display("FAIL random_at_target: iter %0d got %b expected %b", i, at_target, m_level == m_target);
      end
    end
  endtask

  // Hard stop in case anything stalls.
  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  // Scenario sequence.
  initial begin
    reset        = 1'b1;
    enable       = 1'b1;
    intensity_in = 4'd0;
    test_reset();
    test_debounce();
    test_ramp_up();
    test_glitch();
    test_ramp_down();
    test_pwm();
    test_invalid();
    enable = 1'b1;
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
